// File: rtl/resp_tree_pipe_l2.sv
// resp_tree_pipe_l2: priority reduction tree with N_PIPE register stages feeding an output FIFO.
// Defining RESP_TREE_COLLISION_CHECK_EN adds a sticky collision_o flag for multi-valid cycles.
module resp_tree_pipe_l2 #(
  parameter int N_SLAVE = 4,
  parameter int DATA_WIDTH = 64,
  parameter int N_PIPE = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int SRC_W = N_SLAVE > 1 ? $clog2(N_SLAVE) : 1,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_SLAVE-1:0]                  data_r_valid_i,
  input  logic [N_SLAVE-1:0][DATA_WIDTH-1:0]  data_r_rdata_i,
  output logic                                data_r_valid_o,
  output logic [DATA_WIDTH-1:0]               data_r_rdata_o,
  output logic [SRC_W-1:0]                    data_r_src_o,
  input  logic                                data_r_ready_i,
  output logic                                resp_stall_o,
  output logic [CNT_W-1:0]                    fifo_count_o,
  output logic                                overflow_o
`ifdef RESP_TREE_COLLISION_CHECK_EN
  ,
  output logic                                collision_o
`endif
);
  localparam int LV = N_SLAVE > 1 ? $clog2(N_SLAVE) : 0;
  localparam int LEAVES = 2 ** LV;
  localparam int NN = 2 ** (LV + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  // Depth p counts from the root (0) to the leaves (LV); stages spread evenly over the LV+1 depths.
  function automatic bit reg_at(input int p);
    for (int j = 0; j < N_PIPE; j++)
      if (j * (LV + 1) / N_PIPE == p) return 1'b1;
    return 1'b0;
  endfunction
  logic                  v [1:NN-1];
  logic [DATA_WIDTH-1:0] d [1:NN-1];
  logic [SRC_W-1:0]      s [1:NN-1];
  logic [NN-1:1]         reg_v;
  logic [LV:0]           stage_v;
  for (genvar i = 1; i < NN; i++) begin : g_node
    localparam int P = $clog2(i + 1) - 1;
    logic                  cv;
    logic [DATA_WIDTH-1:0] cd;
    logic [SRC_W-1:0]      cs;
    if (i >= LEAVES) begin : g_leaf
      if (i - LEAVES < N_SLAVE) begin : g_used
        assign cv = data_r_valid_i[i-LEAVES];
        assign cd = data_r_rdata_i[i-LEAVES];
        assign cs = SRC_W'(i - LEAVES);
      end else begin : g_pad
        assign cv = 1'b0;
        assign cd = '0;
        assign cs = '0;
      end
    end else begin : g_mux
      assign cv = v[2*i] | v[2*i+1];
      assign cd = v[2*i] ? d[2*i] : d[2*i+1];
      assign cs = v[2*i] ? s[2*i] : s[2*i+1];
    end
    if (reg_at(P)) begin : g_reg
      logic                  rv;
      logic [DATA_WIDTH-1:0] rd;
      logic [SRC_W-1:0]      rs;
      always_ff @(posedge clk) begin
        rv <= rst ? 1'b0 : cv;
        rd <= cd;
        rs <= cs;
      end
      assign v[i] = rv;
      assign d[i] = rd;
      assign s[i] = rs;
      assign reg_v[i] = rv;
    end else begin : g_wire
      assign v[i] = cv;
      assign d[i] = cd;
      assign s[i] = cs;
      assign reg_v[i] = 1'b0;
    end
  end
  // One bit per pipeline stage: each stage can deliver at most one response to the root.
  for (genvar p = 0; p <= LV; p++) begin : g_stage
    assign stage_v[p] = |reg_v[2**(p+1)-1:2**p];
  end
  logic [DATA_WIDTH+SRC_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]               wp, rp;
  logic                        push, pop, full, wr;
  always_comb begin
    push = v[1];
    pop  = data_r_valid_o & data_r_ready_i;
    full = fifo_count_o == CNT_W'(FIFO_DEPTH);
    wr   = push & (~full | pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp           <= '0;
      rp           <= '0;
      fifo_count_o <= '0;
      overflow_o   <= 1'b0;
    end else begin
      wp           <= wp + AW'(wr);
      rp           <= rp + AW'(pop);
      fifo_count_o <= fifo_count_o + CNT_W'(wr) - CNT_W'(pop);
      overflow_o   <= overflow_o | (push & full & ~pop);
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= {s[1], d[1]};
  assign {data_r_src_o, data_r_rdata_o} = mem[rp];
  assign data_r_valid_o = fifo_count_o != '0;
  assign resp_stall_o = (FIFO_DEPTH - int'(fifo_count_o)) <= ($countones(stage_v) + 1);
`ifdef RESP_TREE_COLLISION_CHECK_EN
  always_ff @(posedge clk)
    collision_o <= rst ? 1'b0 : collision_o | ($countones(data_r_valid_i) > 1);
`endif
endmodule

// File: tb/tb_resp_tree_pipe_l2.sv
// tb_resp_tree_pipe_l2: scoreboard bench for resp_tree_pipe_l2 (N_SLAVE=5, N_PIPE=1, FIFO_DEPTH=4).
module tb_resp_tree_pipe_l2;
  localparam int N = 5, W = 16, D = 4, SW = 3, CW = 3;
  logic                clk = 1'b0, rst = 1'b1, ready = 1'b0;
  logic [N-1:0]        valid_i = '0;
  logic [N-1:0][W-1:0] rdata_i = '0;
  logic                valid_o, stall, ovf;
  logic [W-1:0]        rdata_o;
  logic [SW-1:0]       src_o;
  logic [CW-1:0]       count;
`ifdef RESP_TREE_COLLISION_CHECK_EN
  logic                coll;
`endif
  typedef struct packed {logic [W-1:0] d; logic [SW-1:0] s;} exp_t;
  exp_t q[$];
  exp_t e_m;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  resp_tree_pipe_l2 #(.N_SLAVE(N), .DATA_WIDTH(W), .N_PIPE(1), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .data_r_valid_i(valid_i), .data_r_rdata_i(rdata_i),
    .data_r_valid_o(valid_o), .data_r_rdata_o(rdata_o), .data_r_src_o(src_o),
    .data_r_ready_i(ready), .resp_stall_o(stall), .fifo_count_o(count),
    .overflow_o(ovf)
`ifdef RESP_TREE_COLLISION_CHECK_EN
    , .collision_o(coll)
`endif
  );

  // Every accepted output is matched against the scoreboard in order.
  always @(negedge clk) begin
    if (!rst && valid_o && ready) begin
      total++;
      if (q.size() == 0)
        $display("FAIL unexpected_output: got data=%h src=%0d, required none", rdata_o, src_o);
      else begin
        e_m = q.pop_front();
        if ({rdata_o, src_o} !== {e_m.d, e_m.s})
          $display("FAIL output_order: got data=%h src=%0d, required data=%h src=%0d", rdata_o, src_o, e_m.d, e_m.s);
        else passed++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input int ch, input logic [W-1:0] dat, input bit exp);
    @(posedge clk); #1;
    valid_i = '0;
    valid_i[ch] = 1'b1;
    rdata_i[ch] = dat;
    if (exp) q.push_back('{dat, SW'(ch)});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_i = '0;
    end
  endtask

  task automatic drain();
    int c = 0;
    while (q.size() != 0 && c < 30) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; valid_i = '0; ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({valid_o, count, ovf, stall} !== '0)
      $display("FAIL reset_during: valid=%b count=%0d ovf=%b stall=%b, required all 0", valid_o, count, ovf, stall);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({valid_o, count, ovf, stall} !== '0)
      $display("FAIL reset_after: valid=%b count=%0d ovf=%b stall=%b, required all 0", valid_o, count, ovf, stall);
    else passed++;
  endtask

  task automatic test_latency();
    send(2, 16'h00A5, 1'b1);
    ready = 1'b1;
    @(negedge clk);
    total++;
    if (valid_o !== 1'b0) $display("FAIL latency_t0: valid=%b, required 0", valid_o); else passed++;
    idle(1);
    @(negedge clk);
    total++;
    if (valid_o !== 1'b0) $display("FAIL latency_t1: valid=%b, required 0", valid_o); else passed++;
    @(negedge clk);
    total++;
    if (valid_o !== 1'b1 || rdata_o !== 16'h00A5 || src_o !== 3'd2)
      $display("FAIL latency_t2: valid=%b data=%h src=%0d, required 1 00a5 2", valid_o, rdata_o, src_o);
    else passed++;
    @(negedge clk);
    total++;
    if (valid_o !== 1'b0) $display("FAIL latency_t3: valid=%b, required 0", valid_o); else passed++;
  endtask

  task automatic test_order();
    fork
      begin
        for (int k = 0; k < N; k++) send(k, W'(16'h0100 + k), 1'b1);
        idle(1);
      end
      begin
        int c = 0;
        do begin
          @(negedge clk);
          c++;
        end while (!valid_o && c < 10);
        for (int k = 0; k < N; k++) begin
          total++;
          if (valid_o !== 1'b1 || src_o !== SW'(k))
            $display("FAIL order_src%0d: valid=%b src=%0d, required 1 %0d", k, valid_o, src_o, k);
          else passed++;
          @(negedge clk);
        end
      end
    join
  endtask

  task automatic test_overflow();
    @(posedge clk); #1;
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(1, W'(16'h0200 + k), k < 4);
      @(negedge clk);
      if (k == 2) begin
        total++;
        if (stall !== 1'b0 || count !== 3'd1)
          $display("FAIL stall_early: stall=%b count=%0d, required 0 1", stall, count);
        else passed++;
      end
      if (k == 3) begin
        total++;
        if (stall !== 1'b1 || count !== 3'd2)
          $display("FAIL stall_before_fourth: stall=%b count=%0d, required 1 2", stall, count);
        else passed++;
      end
    end
    idle(3);
    @(negedge clk);
    total++;
    if (count !== 3'd4 || ovf !== 1'b1 || stall !== 1'b1)
      $display("FAIL overflow_full: count=%0d ovf=%b stall=%b, required 4 1 1", count, ovf, stall);
    else passed++;
    @(posedge clk); #1;
    ready = 1'b1;
    drain();
    total++;
    if (q.size() != 0 || valid_o !== 1'b0 || count !== 3'd0)
      $display("FAIL overflow_drain: left=%0d valid=%b count=%0d, required 0 0 0", q.size(), valid_o, count);
    else passed++;
    total++;
    if (ovf !== 1'b1) $display("FAIL overflow_sticky: ovf=%b, required 1", ovf); else passed++;
  endtask

  task automatic test_full_simul();
    for (int k = 0; k < 4; k++) send(2, W'(16'h0400 + k), 1'b1);
    idle(3);
    @(negedge clk);
    total++;
    if (count !== 3'd4 || stall !== 1'b1)
      $display("FAIL full_fill: count=%0d stall=%b, required 4 1", count, stall);
    else passed++;
    send(3, 16'h04AA, 1'b1);
    @(posedge clk); #1;
    valid_i = '0;
    ready = 1'b1;
    @(negedge clk);
    total++;
    if (count !== 3'd4) $display("FAIL full_pending: count=%0d, required 4", count); else passed++;
    @(posedge clk); #1;
    ready = 1'b0;
    @(negedge clk);
    total++;
    if (count !== 3'd4 || ovf !== 1'b0)
      $display("FAIL full_push_pop: count=%0d ovf=%b, required 4 0", count, ovf);
    else passed++;
    @(posedge clk); #1;
    ready = 1'b1;
    drain();
    total++;
    if (q.size() != 0 || valid_o !== 1'b0 || ovf !== 1'b0)
      $display("FAIL full_drain: left=%0d valid=%b ovf=%b, required 0 0 0", q.size(), valid_o, ovf);
    else passed++;
  endtask

  task automatic test_multi();
    @(posedge clk); #1;
    ready = 1'b1;
    valid_i = 5'b00011;
    rdata_i[0] = 16'h0311;
    rdata_i[1] = 16'h0322;
    q.push_back('{16'h0311, 3'd0});
    idle(1);
`ifdef RESP_TREE_COLLISION_CHECK_EN
    @(negedge clk);
    total++;
    if (coll !== 1'b1) $display("FAIL collision_flag: got %b, required 1", coll); else passed++;
`endif
    drain();
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0 || valid_o !== 1'b0 || count !== 3'd0)
      $display("FAIL multi_single: left=%0d valid=%b count=%0d, required 0 0 0", q.size(), valid_o, count);
    else passed++;
  endtask

  task automatic test_reset_inflight();
    @(posedge clk); #1;
    ready = 1'b0;
    for (int k = 0; k < 3; k++) send(4, W'(16'h0500 + k), 1'b0);
    send(4, 16'h05FF, 1'b0);
    @(posedge clk); #1;
    valid_i = '0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (count !== 3'd3 || stall !== 1'b1)
      $display("FAIL inflight_pre: count=%0d stall=%b, required 3 1", count, stall);
    else passed++;
    @(negedge clk);
    total++;
    if (count !== 3'd0 || valid_o !== 1'b0 || ovf !== 1'b0)
      $display("FAIL inflight_reset: count=%0d valid=%b ovf=%b, required 0 0 0", count, valid_o, ovf);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    ready = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (count !== 3'd0 || valid_o !== 1'b0)
      $display("FAIL inflight_gone: count=%0d valid=%b, required 0 0", count, valid_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_order();
    test_overflow();
    test_reset();
    test_full_simul();
    test_multi();
    test_reset_inflight();
    total++;
    if (q.size() != 0) $display("FAIL scoreboard_left: %0d entries, required 0", q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
